// File: rtl/bf16_mult_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_mult_arbiter
//
// Shares one external, fully pipelined bfloat16 multiplier between N
// requesters. A round-robin arbiter grants at most one eligible requester per
// cycle and registers its operands onto mul_a/mul_b. A tag shift register
// follows each operation down the multiplier pipeline. When the tag reaches
// the last stage, mul_out is captured into that requester's result slot.
// Each requester may have at most one operation outstanding. That covers
// both an operation in flight and an unconsumed result.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : [N]     per-requester operation request
//   req_a/b    : [N*16]  bf16 operands, requester i on [16i+15:16i]
//   req_ready  : [N]     accept strobe (combinational, one-hot or zero)
//   rsp_valid  : [N]     result held for requester i
//   rsp_data   : [N*16]  bf16 product, sliced like req_a
//   rsp_ready  : [N]     result consume strobe
//   mul_a/b    : [16]    registered operands to the shared multiplier
//   mul_out    : [16]    multiplier product, LAT edges after operand sampling
//   busy       : any operation in flight or any result held
// ---------------------------------------------------------------------------
module bf16_mult_arbiter #(
  parameter int N   = 4,
  parameter int LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*16-1:0] req_a,
  input  logic [N*16-1:0] req_b,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [N*16-1:0] rsp_data,
  input  logic [N-1:0]    rsp_ready,
  output logic [15:0]     mul_a,
  output logic [15:0]     mul_b,
  input  logic [15:0]     mul_out,
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;

  // Registered state
  logic [IW-1:0]   r_last_grant;
  logic [N-1:0]    r_inflight;
  logic [N-1:0]    r_rsp_valid;
  logic [N*16-1:0] r_rsp_data;
  logic [15:0]     r_mul_a;
  logic [15:0]     r_mul_b;
  tag_t            r_tag [LAT+1];

  // Combinational arbitration and capture decode
  logic [N-1:0]    w_eligible;
  logic [N-1:0]    w_hi_mask;
  logic [N-1:0]    w_hi_eligible;
  logic [N-1:0]    w_cand;
  logic [N-1:0]    w_grant;
  logic [IW-1:0]   w_grant_id;
  logic            w_accept;
  logic [15:0]     w_sel_a;
  logic [15:0]     w_sel_b;
  logic [N-1:0]    w_cap_mask;
  tag_t            w_last_tag;

  // A requester that is consuming its result this cycle still has
  // rsp_valid set, so it is not eligible until the following cycle.
  assign w_eligible = req_valid & ~r_inflight & ~r_rsp_valid;

  // Round-robin: prefer eligible requesters above last_grant. If none,
  // wrap around to the lowest eligible index.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_hi_mask[i] = (i > int'(r_last_grant));
    end
  end

  assign w_hi_eligible = w_eligible & w_hi_mask;
  assign w_cand        = (|w_hi_eligible) ? w_hi_eligible : w_eligible;

  // Pick the lowest set bit of the candidate vector.
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
        w_grant_id = IW'(i);
      end
    end
  end

  // The grant is already qualified by req_valid, so any ready bit is an accept.
  assign req_ready = w_grant & {N{rst_n}};
  assign w_accept  = |req_ready;

  // One-hot operand mux for the granted requester.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[16*i +: 16];
        w_sel_b = req_b[16*i +: 16];
      end
    end
  end

  // A valid tag in the last stage means mul_out belongs to that requester now.
  assign w_last_tag = r_tag[LAT];

  always_comb begin
    w_cap_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_cap_mask[i] = w_last_tag.valid && (int'(w_last_tag.id) == i);
    end
  end

  // Control state: reset clears everything that can produce a future result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= IW'(N - 1);
      r_inflight   <= '0;
      r_rsp_valid  <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      for (int k = 0; k <= LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every stage shifts from pre-edge values.
      r_tag[0] <= tag_t'{valid: w_accept, id: w_grant_id};
      for (int k = 1; k <= LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end

      if (w_accept) begin
        r_mul_a      <= w_sel_a;
        r_mul_b      <= w_sel_b;
        r_last_grant <= w_grant_id;
      end

      // Accept and capture never hit the same bit. Accept requires
      // in-flight clear, and capture implies in-flight set.
      r_inflight  <= (r_inflight | req_ready) & ~w_cap_mask;
      // Consume clears only held slots. Capture into another slot on the
      // same edge is independent of it.
      r_rsp_valid <= (r_rsp_valid & ~rsp_ready) | w_cap_mask;
    end
  end

  // NOTE: result storage has no reset, because its contents are don't-care while rsp_valid is low.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_cap_mask[i]) begin
        r_rsp_data[16*i +: 16] <= mul_out;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign busy      = (|r_inflight) | (|r_rsp_valid);

endmodule

// File: tb/tb_bf16_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bf16_mult_arbiter
//
// Drives directed scenarios, followed by a random phase, into
// bf16_mult_arbiter. A LAT-deep bf16 multiplier model sits behind
// mul_a/mul_b. Every accept pushes {id, expected product, accept edge} into a
// scoreboard queue. Every rising rsp_valid bit pops the queue and checks the
// id, the data and the accept-to-result latency.
// ---------------------------------------------------------------------------
module tb_bf16_mult_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*16-1:0] rsp_data;
  logic [N-1:0]    rsp_ready;
  logic [15:0]     mul_a;
  logic [15:0]     mul_b;
  logic [15:0]     mul_out;
  logic            busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          acc_edge;
  } sb_t;

  sb_t        sb_q [$];
  logic [N-1:0] prev_rsp_valid = '0;
  logic [15:0]  mul_pipe [LAT];

  bf16_mult_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference bf16 multiply for normal operands. It truncates the mantissa
  // and flushes zero or denormal inputs to a signed zero.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [15:0] p;
    logic [6:0]  m;
    int          e;
    s = a[15] ^ b[15];
    if (a[14:7] == 8'h00 || b[14:7] == 8'h00) return {s, 15'h0000};
    p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (p[15]) begin
      m = p[14:8];
      e = e + 1;
    end else begin
      m = p[13:7];
    end
    return {s, e[7:0], m};
  endfunction

  function automatic logic [15:0] rand_bf16();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 7'($urandom)};
  endfunction

  // Multiplier model: samples mul_a/mul_b at each edge and presents the
  // product on mul_out LAT edges later.
  always @(posedge clk) begin
    mul_pipe[0] <= bf16_mul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
  end
  assign mul_out = mul_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && !prev_rsp_valid[i]) begin
          check("sb_pending", (sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            check("sb_id", i, e.id);
            check("sb_data", rsp_data[16*i +: 16], e.data);
            check("sb_latency", cyc - e.acc_edge, LAT + 1);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_q.push_back('{id: i,
                           data: bf16_mul(req_a[16*i +: 16], req_b[16*i +: 16]),
                           acc_edge: cyc + 1});
        end
      end
    end
    prev_rsp_valid = rsp_valid;
  end

  // Bounded wait for a result bit to rise.
  task automatic wait_rsp(input int i, input string tag);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < 40) begin
      tick();
      n++;
    end
    check(tag, rsp_valid[i], 1'b1);
  endtask

  task automatic single_op(input string tag);
    int n;
    req_a[15:0] = 16'h3F80;
    req_b[15:0] = 16'h4000;
    req_valid   = 4'b0001;
    #1;
    check({tag, "_ready"}, req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check({tag, "_mul_a"}, mul_a, 16'h3F80);
    check({tag, "_mul_b"}, mul_b, 16'h4000);
    check({tag, "_busy_inflight"}, busy, 1'b1);
    n = 0;
    while (!rsp_valid[0] && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, LAT + 1);
    check({tag, "_data"}, rsp_data[15:0], 16'h4000);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    check({tag, "_rsp_clear"}, rsp_valid, 4'b0000);
    check({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic seen;

    // Reset state. Requests are asserted to show that ready stays low.
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    tick();
    tick();
    check("rst_ready_low", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_mul_a", mul_a, 16'h0000);
    check("rst_mul_b", mul_b, 16'h0000);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // Single operation on requester 0.
    single_op("single");

    // All four requesters valid from reset: grants 0,1,2,3 back to back.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'h3F80 + 16'(i);
      req_b[16*i +: 16] = 16'h4040 + 16'(i << 1);
    end
    req_valid = '1;
    #1;
    check("all_grant0", req_ready, 4'b0001);
    tick();
    check("all_grant1", req_ready, 4'b0010);
    tick();
    check("all_grant2", req_ready, 4'b0100);
    tick();
    check("all_grant3", req_ready, 4'b1000);
    tick();
    check("all_grant_none", req_ready, 4'b0000);
    req_valid = '0;
    wait_rsp(0, "all_rsp0_wait");
    check("all_rsp_0", rsp_valid, 4'b0001);
    tick();
    check("all_rsp_01", rsp_valid, 4'b0011);
    tick();
    check("all_rsp_012", rsp_valid, 4'b0111);
    tick();
    check("all_rsp_0123", rsp_valid, 4'b1111);
    rsp_ready = '1;
    tick();
    rsp_ready = '0;
    check("all_consumed", rsp_valid, 4'b0000);

    // Held request with a stalled result: no re-grant until one cycle after consume.
    req_a[15:0] = 16'h4040;
    req_b[15:0] = 16'h4080;
    req_valid   = 4'b0001;
    #1;
    check("hold_first_grant", req_ready, 4'b0001);
    tick();
    check("hold_no_regrant_inflight", req_ready, 4'b0000);
    wait_rsp(0, "hold_rsp_wait");
    tick();
    tick();
    check("hold_no_regrant_held", req_ready, 4'b0000);
    rsp_ready = 4'b0001;
    #1;
    check("hold_no_grant_on_consume", req_ready, 4'b0000);
    tick();
    rsp_ready = '0;
    #1;
    check("hold_regrant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_rsp(0, "hold_rsp2_wait");
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;

    // Round-robin fairness: with 0,2,3 requesting, the order is 2, 3, 0.
    req_valid = 4'b1101;
    #1;
    check("rr_grant_2", req_ready, 4'b0100);
    tick();
    check("rr_grant_3", req_ready, 4'b1000);
    tick();
    check("rr_grant_0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (rsp_valid == 4'b1101) seen = 1'b1;
      else tick();
    end
    check("rr_all_rsp", rsp_valid, 4'b1101);
    rsp_ready = '1;
    tick();
    rsp_ready = '0;

    // Consume slot 1 on the same edge that captures into slot 2.
    req_valid = 4'b0110;
    #1;
    check("cc_grant_1", req_ready, 4'b0010);
    tick();
    check("cc_grant_2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_rsp(1, "cc_rsp1_wait");
    check("cc_before", rsp_valid, 4'b0010);
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    check("cc_after", rsp_valid, 4'b0100);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;

    // Reset two edges after an accept discards that operation.
    req_a[15:0] = 16'h4100;
    req_b[15:0] = 16'h4100;
    req_valid   = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 4'b0000);
    check("midrst_mul_a", mul_a, 16'h0000);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      seen = seen | (|rsp_valid);
    end
    check("midrst_no_rsp", seen, 1'b0);
    single_op("post_rst");

    // Random traffic. The scoreboard checks every result.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        req_a[16*i +: 16] = rand_bf16();
        req_b[16*i +: 16] = rand_bf16();
      end
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      #1;
      check("rnd_onehot", $onehot0(req_ready), 1'b1);
      check("rnd_subset", req_ready & ~req_valid, 4'b0000);
      tick();
    end

    // Drain.
    req_valid = '0;
    rsp_ready = '1;
    for (int n = 0; n < 20; n++) tick();
    rsp_ready = '0;
    check("drain_busy", busy, 1'b0);
    check("drain_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
